// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads instruction memory combinationally
// and presents one registered instruction per cycle to decode over valid/ready.
//
// state | meaning
// ------+----------------------------------------------------------------
// FETCH | reading memory at pc_q, capturing into the output slot when free
// FAULT | out-of-range or misaligned fetch seen; no reads until redirect/rst
module fetch_stage #(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h01000000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i,
  input  logic              mem_valid_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic [AWIDTH-1:0] pc_o,
  output logic              insn_valid_o,
  input  logic              insn_ready_i,
  output logic              fault_o,
  output logic [AWIDTH-1:0] fault_pc_o,
  output logic [31:0]       fetch_count_o
);

  typedef enum logic {FETCH = 1'b0, FAULT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] insn_q, insn_d;
  logic [AWIDTH-1:0] pc_out_q, pc_out_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic [AWIDTH-1:0] fault_pc_q, fault_pc_d;
  logic [31:0]       count_q, count_d;

  logic slot_free;
  logic handshake;

  assign slot_free = !valid_q || insn_ready_i;
  assign handshake = valid_q && insn_ready_i;

  assign mem_addr_o     = pc_q;
  assign mem_read_en_o  = (state_q == FETCH) && !rst;
  assign mem_write_en_o = 1'b0;

  assign insn_o        = insn_q;
  assign pc_o          = pc_out_q;
  assign insn_valid_o  = valid_q;
  assign fault_o       = fault_q;
  assign fault_pc_o    = fault_pc_q;
  assign fetch_count_o = count_q;

  // State and datapath registers; reset clears everything with no partial capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= BASE_ADDR;
      insn_q     <= '0;
      pc_out_q   <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      insn_q     <= insn_d;
      pc_out_q   <= pc_out_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  // Next-state logic: redirect wins over everything, then drain/capture/fault.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    insn_d     = insn_q;
    pc_out_d   = pc_out_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;

    if (redirect_i) begin
      // A flushed slot is not a handoff, so the count is left alone.
      valid_d = 1'b0;
      if (redirect_pc_i[1:0] == 2'b00) begin
        pc_d    = redirect_pc_i;
        state_d = FETCH;
        fault_d = 1'b0;
      end else begin
        state_d    = FAULT;
        fault_d    = 1'b1;
        fault_pc_d = redirect_pc_i;
      end
    end else begin
      if (handshake) begin
        count_d = count_q + 32'd1;
        valid_d = 1'b0;
      end
      if (state_q == FETCH) begin
        if (mem_valid_i) begin
          // When the slot is blocked pc_q holds and the same word is re-read.
          if (slot_free) begin
            insn_d   = mem_data_i;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + AWIDTH'(4);
          end
        end else begin
          state_d    = FAULT;
          fault_d    = 1'b1;
          fault_pc_d = pc_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed test-plan scenarios followed by
// randomized ready/redirect traffic, all compared against a slot/queue model.
module tb_fetch_stage;

  localparam logic [31:0] BASE  = 32'h01000000;
  localparam int          DEPTH = 16;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_data;
  logic        mem_valid;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] insn;
  logic [31:0] pc;
  logic        insn_valid;
  logic        insn_ready;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  logic [31:0] mem [DEPTH];

  int n_chk  = 0;
  int n_pass = 0;

  fetch_stage #(.AWIDTH(32), .DWIDTH(32), .BASE_ADDR(BASE)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_addr_o    (mem_addr),
    .mem_read_en_o (mem_read_en),
    .mem_write_en_o(mem_write_en),
    .mem_data_i    (mem_data),
    .mem_valid_i   (mem_valid),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .insn_o        (insn),
    .pc_o          (pc),
    .insn_valid_o  (insn_valid),
    .insn_ready_i  (insn_ready),
    .fault_o       (fault),
    .fault_pc_o    (fault_pc),
    .fetch_count_o (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit in_range(input logic [31:0] a);
    return ({32'd0, a} >= {32'd0, BASE}) && ({32'd0, a} < {32'd0, BASE} + 64'(4 * DEPTH));
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return mem[off[3:0]];
  endfunction

  // Behavioural memory: combinational read, valid only for enabled in-range reads.
  assign mem_valid = mem_read_en && in_range(mem_addr);
  assign mem_data  = in_range(mem_addr) ? word_at(mem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: the output slot is a queue holding at most one entry;
  // m_next is the address the stage will fetch next, m_fault gates fetching.
  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
  } ent_t;

  ent_t        slot[$];
  logic [31:0] m_next;
  bit          m_fault;
  logic [31:0] m_fault_pc;
  logic [31:0] m_count;

  task automatic model_reset();
    slot.delete();
    m_next     = BASE;
    m_fault    = 0;
    m_fault_pc = 0;
    m_count    = 0;
  endtask

  task automatic model_edge(input bit rdy, input bit rd, input logic [31:0] rpc);
    bit had_entry;
    bit room;
    had_entry = slot.size() != 0;
    room      = !had_entry || rdy;
    if (rd) begin
      slot.delete();
      if (rpc % 4 == 0) begin
        m_next  = rpc;
        m_fault = 0;
      end else begin
        m_fault    = 1;
        m_fault_pc = rpc;
      end
    end else begin
      if (had_entry && rdy) begin
        void'(slot.pop_front());
        m_count = m_count + 1;
      end
      if (!m_fault) begin
        if (!in_range(m_next)) begin
          m_fault    = 1;
          m_fault_pc = m_next;
        end else if (room) begin
          slot.push_back('{insn: word_at(m_next), pc: m_next});
          m_next = m_next + 4;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("valid", {31'd0, insn_valid}, {31'd0, slot.size() != 0});
    if (slot.size() != 0) begin
      chk("insn", insn, slot[0].insn);
      chk("pc", pc, slot[0].pc);
    end
    chk("mem_addr", mem_addr, m_next);
    chk("read_en", {31'd0, mem_read_en}, {31'd0, !m_fault});
    chk("write_en", {31'd0, mem_write_en}, 32'd0);
    chk("fault", {31'd0, fault}, {31'd0, m_fault});
    chk("fault_pc", fault_pc, m_fault_pc);
    chk("count", fetch_count, m_count);
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, compare.
  task automatic cyc(input bit rdy, input bit rd, input logic [31:0] rpc);
    insn_ready  = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    @(posedge clk);
    model_edge(rdy, rd, rpc);
    #1;
    compare_all();
    redirect = 1'b0;
  endtask

  // Half-cycle reset pulse between edges; outputs must clear before any edge.
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, insn_valid}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_addr", mem_addr, BASE);
    chk("rst_read_en", {31'd0, mem_read_en}, 32'd0);
    chk("rst_insn", insn, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    model_reset();
    #2 rst = 1'b0;
  endtask

  logic [31:0] tgt;
  logic [31:0] cnt_before;

  initial begin
    mem[0] = 32'h00000013;
    mem[1] = 32'h00100093;
    mem[2] = 32'h00200113;
    for (int i = 3; i < DEPTH; i++) mem[i] = $urandom;

    rst         = 1'b1;
    insn_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    model_reset();
    #1;
    chk("init_valid", {31'd0, insn_valid}, 32'd0);
    chk("init_addr", mem_addr, BASE);
    chk("init_count", fetch_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming with ready high.
    cyc(1, 0, 0);
    chk("s0_insn", insn, 32'h00000013);
    chk("s0_pc", pc, 32'h01000000);
    cyc(1, 0, 0);
    chk("s1_insn", insn, 32'h00100093);
    chk("s1_pc", pc, 32'h01000004);
    cyc(1, 0, 0);
    chk("s2_insn", insn, 32'h00200113);
    chk("s2_pc", pc, 32'h01000008);
    cyc(1, 0, 0);
    chk("s_count", fetch_count, 32'd3);

    // Back-pressure right after the first capture.
    pulse_reset();
    cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0);
      chk("bp_insn", insn, 32'h00000013);
      chk("bp_pc", pc, 32'h01000000);
      chk("bp_addr", mem_addr, 32'h01000004);
    end
    cyc(1, 0, 0);
    chk("bp_next_insn", insn, 32'h00100093);
    chk("bp_next_pc", pc, 32'h01000004);

    // Redirect while the slot is held by back-pressure.
    cnt_before = fetch_count;
    cyc(0, 1, 32'h01000008);
    chk("rd_valid", {31'd0, insn_valid}, 32'd0);
    chk("rd_addr", mem_addr, 32'h01000008);
    cyc(0, 0, 0);
    chk("rd_insn", insn, 32'h00200113);
    chk("rd_pc", pc, 32'h01000008);
    chk("rd_count", fetch_count, cnt_before);

    // Run off the end of memory.
    cyc(1, 1, BASE + 4 * (DEPTH - 2));
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("end_last_pc", pc, BASE + 4 * (DEPTH - 1));
    cnt_before = fetch_count;
    cyc(1, 0, 0);
    chk("end_fault", {31'd0, fault}, 32'd1);
    chk("end_fault_pc", fault_pc, BASE + 4 * DEPTH);
    chk("end_read_en", {31'd0, mem_read_en}, 32'd0);
    chk("end_handoff", fetch_count, cnt_before + 1);
    cyc(1, 0, 0);
    cyc(1, 1, BASE);
    chk("end_clear", {31'd0, fault}, 32'd0);
    cyc(1, 0, 0);
    chk("end_resume", insn, 32'h00000013);

    // Misaligned redirect.
    cyc(0, 1, 32'h01000006);
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h01000006);
    chk("mis_valid", {31'd0, insn_valid}, 32'd0);
    chk("mis_read_en", {31'd0, mem_read_en}, 32'd0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);

    // PC wrap: last aligned address is out of range and faults on the next edge.
    cyc(1, 1, 32'hFFFFFFFC);
    cyc(1, 0, 0);
    chk("wrap_fault_pc", fault_pc, 32'hFFFFFFFC);
    cyc(1, 1, BASE);
    cyc(1, 0, 0);
    cyc(0, 0, 0);

    // Mid-stream reset.
    pulse_reset();
    cyc(1, 0, 0);
    chk("post_rst_insn", insn, 32'h00000013);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      bit rd;
      rd = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 5))
        0, 1, 2: tgt = BASE + 4 * $urandom_range(0, DEPTH - 1);
        3:       tgt = BASE + 4 * $urandom_range(DEPTH - 3, DEPTH + 2);
        4:       tgt = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
        default: tgt = 32'hFFFFFFFC;
      endcase
      cyc($urandom_range(0, 3) != 0, rd, tgt);
      if ($urandom_range(0, 149) == 0) pulse_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
